regfile_initiator: RTL
======================

# regfile_initiator

Bus-initiator counterpart to the 32×32-bit register-file storage block. Accepts read and write commands on a valid/ready command channel. Sequences them onto the register file's `mode`/`address`/`data_in`/`write_enable` port, including multi-beat bursts with address wrap. Returns read data on a valid/ready response channel with backpressure. It sits between control logic (or a testbench sequencer) and the register file, so the storage never sees raw handshake traffic.

## Interface
- `ADDR_W`, 5, register-file address width (32 entries)
- `DATA_W`, 32, data width
- `READ_LATENCY`, 1, edges from address presented to valid `mem_data_out`; legal range 1..4
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-low reset: sampled on rising `clk`, 0 = reset
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  command accepted when both valid and ready are high
- `cmd_write`  in  1  1 = write (fill) burst, 0 = read burst
- `cmd_addr`  in  ADDR_W  start address
- `cmd_len`  in  ADDR_W  beats minus one (0 = 1 beat, 31 = 32 beats)
- `cmd_wdata`  in  DATA_W  write data, written to every beat of the burst
- `rsp_valid`  out  1  read beat available
- `rsp_ready`  in  1  consumer accepts the beat
- `rsp_addr`  out  ADDR_W  address of the returned beat
- `rsp_data`  out  DATA_W  read data
- `mem_mode`  out  1  1 = write access, 0 = read access
- `mem_address`  out  ADDR_W  register-file address
- `mem_data_in`  out  DATA_W  register-file write data
- `mem_write_enable`  out  1  write strobe
- `mem_data_out`  in  DATA_W  register-file read data
- `busy`  out  1  high whenever the FSM is not in IDLE
- `verify_error`  out  1  sticky read-back mismatch flag (see Configuration)

## Operation
- FSM states: IDLE, WRITE, RADDR, RWAIT, RESP, plus VADDR/VWAIT when `REGFILE_INITIATOR_VERIFY_EN` is defined.
- IDLE: `cmd_ready` = 1. On the handshake, latch addr, len, wdata and write.
  - Go to WRITE if `cmd_write` = 1, otherwise RADDR.
- WRITE: drive `mem_mode` = 1, `mem_write_enable` = 1, `mem_address` = current address, `mem_data_in` = latched wdata for one cycle per beat.
  - Address increments per beat, modulo 2^ADDR_W; 31 wraps to 0.
  - After the last beat, go to IDLE.
- RADDR: drive `mem_mode` = 0, `mem_write_enable` = 0, `mem_address` = current address, then go to RWAIT.
- RWAIT: count `READ_LATENCY`−1 further cycles, holding the address.
  - On the final edge, capture `mem_data_out` into `rsp_data` and the address into `rsp_addr`, then go to RESP.
- RESP: `rsp_valid` = 1. `rsp_data` and `rsp_addr` stay stable until `rsp_ready`.
  - On the handshake: go to RADDR with address+1 if beats remain, otherwise IDLE.
- `mem_write_enable` is never high outside WRITE.
- `mem_mode` and `mem_data_in` hold their last values when idle.
- Only one command is in flight at a time; there is no command queue.
- `busy` = !IDLE.

## Timing
- Reset (`reset` = 0 at an edge): FSM goes to IDLE and every output is 0, except `cmd_ready`, which is 1 from the first cycle after reset deasserts.
- Reset mid-burst aborts immediately. No further `mem_write_enable` pulses occur, and a pending response is dropped.
- Write burst accepted at edge T: beat k is written at edge T+1+k. Back in IDLE, with `cmd_ready` = 1, at cycle T+len+2.
- Read beat: address is presented in the cycle after entering RADDR. `rsp_valid` rises READ_LATENCY cycles after that address cycle.
- Minimum read throughput is one beat per READ_LATENCY+2 cycles when `rsp_ready` is held high.
- `rsp_ready` held low stalls indefinitely, with no loss and no re-read.
- `cmd_valid` while busy is ignored; `cmd_ready` = 0 and the command fields are don't-care.

## Configuration
- `REGFILE_INITIATOR_VERIFY_EN` defined:
  - After each WRITE beat, the FSM enters VADDR and issues a read of the same address, then VWAIT for the latency.
  - It compares `mem_data_out` with wdata. On mismatch it sets `verify_error`, which stays set until reset.
  - Each write beat costs 2+READ_LATENCY cycles.
- Not defined:
  - `verify_error` is tied to 0.
  - No VADDR/VWAIT states exist, and write timing is exactly as in Timing.

## Structure
- Shared package `regfile_pkg`:
  - FSM state enum.
  - `ADDR_W` and `DATA_W` defaults.
  - Typedef for the command struct {write, addr, len, wdata}.
- One sub-module, `regfile_init_latcnt`: a down-counter that loads `READ_LATENCY`−1 and flags zero. It is used by RWAIT and VWAIT.

## Test plan
- Reset held low for 5 cycles with `cmd_valid` = 1 → all outputs 0 and no `mem_write_enable` pulse; `cmd_ready` = 1 one cycle after release.
- Single write: addr 22, data 324560, len 0 → exactly one `mem_write_enable` pulse, with `mem_address` = 22 and `mem_data_in` = 324560; then read addr 22 → `rsp_data` = 324560, `rsp_addr` = 22.
- Wrap burst: write addr 30, len 3, data 1324140 → writes to 30, 31, 0, 1; a read burst of the same range returns 4 beats in that address order.
- Backpressure: read addr 25 with `rsp_ready` low for 10 cycles → `rsp_valid` and data held stable; exactly one beat is delivered on release, with no duplicate.
- Reset asserted during beat 2 of an 8-beat write → no `mem_write_enable` after the reset edge; FSM returns to IDLE.
- With `REGFILE_INITIATOR_VERIFY_EN`, a bench model corrupts the read of addr 23 → `verify_error` = 1 and stays set until reset; with uncorrupted data it stays 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types for the register-file initiator: FSM states, command record, width defaults.
// The VADDR/VWAIT states exist only when REGFILE_INITIATOR_VERIFY_EN is defined.
package regfile_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 32;
  // Enough for READ_LATENCY-1 with READ_LATENCY up to 4.
  localparam int LAT_CNT_W  = 2;

`ifdef REGFILE_INITIATOR_VERIFY_EN
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_RADDR = 3'd2,
    S_RWAIT = 3'd3,
    S_RESP  = 3'd4,
    S_VADDR = 3'd5,
    S_VWAIT = 3'd6
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_RADDR = 3'd2,
    S_RWAIT = 3'd3,
    S_RESP  = 3'd4
  } state_t;
`endif

  typedef struct packed {
    logic                  write;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_ADDR_W-1:0] len;
    logic [DEF_DATA_W-1:0] wdata;
  } cmd_t;

endpackage

// File: rtl/regfile_init_latcnt.sv
// Read-latency down-counter: loads READ_LATENCY-1 and flags when it reaches zero.
module regfile_init_latcnt
  import regfile_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  output logic zero_o
);

  logic [LAT_CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= LAT_CNT_W'(READ_LATENCY - 1);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/regfile_initiator.sv
// Sequences valid/ready read/write burst commands onto a register-file port.
// REGFILE_INITIATOR_VERIFY_EN adds a read-back check after every written beat.
//
// state   | meaning
// IDLE    | ready for a command
// WRITE   | one write beat on the memory port
// RADDR   | read address presented
// RWAIT   | waiting out the remaining read latency
// RESP    | read beat offered on the response channel
// VADDR   | read-back address presented (verify build only)
// VWAIT   | read-back latency, then compare (verify build only)
module regfile_initiator
  import regfile_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [DATA_W-1:0] rsp_data,
  output logic              mem_mode,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_write_enable,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              busy,
  output logic              verify_error
);

  state_t            state_q;
  cmd_t              cmd_in;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] len_q;
  logic [DATA_W-1:0] wdata_q;
  logic              cmd_ready_q;
  logic              rsp_valid_q;
  logic [ADDR_W-1:0] rsp_addr_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              mem_mode_q;
  logic [ADDR_W-1:0] mem_address_q;
  logic [DATA_W-1:0] mem_data_in_q;
  logic              mem_we_q;
  logic              lat_load;
  logic              lat_zero;

  assign cmd_in = {cmd_write, cmd_addr, cmd_len, cmd_wdata};

`ifdef REGFILE_INITIATOR_VERIFY_EN
  logic verify_error_q;
  assign lat_load = (state_q == S_RADDR) || (state_q == S_VADDR);
`else
  assign lat_load = (state_q == S_RADDR);
`endif

  regfile_init_latcnt #(
    .READ_LATENCY(READ_LATENCY)
  ) u_latcnt (
    .clk   (clk),
    .reset (reset),
    .load_i(lat_load),
    .zero_o(lat_zero)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      len_q         <= '0;
      wdata_q       <= '0;
      cmd_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_addr_q    <= '0;
      rsp_data_q    <= '0;
      mem_mode_q    <= 1'b0;
      mem_address_q <= '0;
      mem_data_in_q <= '0;
      mem_we_q      <= 1'b0;
`ifdef REGFILE_INITIATOR_VERIFY_EN
      verify_error_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_valid && cmd_ready_q) begin
            cmd_ready_q   <= 1'b0;
            addr_q        <= cmd_in.addr;
            len_q         <= cmd_in.len;
            wdata_q       <= cmd_in.wdata;
            mem_address_q <= cmd_in.addr;
            if (cmd_in.write) begin
              state_q       <= S_WRITE;
              mem_mode_q    <= 1'b1;
              mem_we_q      <= 1'b1;
              mem_data_in_q <= cmd_in.wdata;
            end else begin
              state_q    <= S_RADDR;
              mem_mode_q <= 1'b0;
            end
          end
        end

        S_WRITE: begin
`ifdef REGFILE_INITIATOR_VERIFY_EN
          mem_we_q   <= 1'b0;
          mem_mode_q <= 1'b0;
          state_q    <= S_VADDR;
`else
          if (len_q == '0) begin
            mem_we_q    <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end else begin
            addr_q        <= addr_q + 1'b1;
            len_q         <= len_q - 1'b1;
            mem_address_q <= addr_q + 1'b1;
          end
`endif
        end

        S_RADDR: state_q <= S_RWAIT;

        S_RWAIT: begin
          if (lat_zero) begin
            rsp_data_q  <= mem_data_out;
            rsp_addr_q  <= addr_q;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end
        end

        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            if (len_q == '0) begin
              cmd_ready_q <= 1'b1;
              state_q     <= S_IDLE;
            end else begin
              addr_q        <= addr_q + 1'b1;
              len_q         <= len_q - 1'b1;
              mem_address_q <= addr_q + 1'b1;
              state_q       <= S_RADDR;
            end
          end
        end

`ifdef REGFILE_INITIATOR_VERIFY_EN
        S_VADDR: state_q <= S_VWAIT;

        S_VWAIT: begin
          if (lat_zero) begin
            if (mem_data_out != wdata_q) verify_error_q <= 1'b1;
            if (len_q == '0) begin
              cmd_ready_q <= 1'b1;
              state_q     <= S_IDLE;
            end else begin
              addr_q        <= addr_q + 1'b1;
              len_q         <= len_q - 1'b1;
              mem_address_q <= addr_q + 1'b1;
              mem_mode_q    <= 1'b1;
              mem_we_q      <= 1'b1;
              state_q       <= S_WRITE;
            end
          end
        end
`endif

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready        = cmd_ready_q;
  assign rsp_valid        = rsp_valid_q;
  assign rsp_addr         = rsp_addr_q;
  assign rsp_data         = rsp_data_q;
  assign mem_mode         = mem_mode_q;
  assign mem_address      = mem_address_q;
  assign mem_data_in      = mem_data_in_q;
  assign mem_write_enable = mem_we_q;
  assign busy             = (state_q != S_IDLE);

`ifdef REGFILE_INITIATOR_VERIFY_EN
  assign verify_error = verify_error_q;
`else
  assign verify_error = 1'b0;
`endif

endmodule
